// File: rtl/count_seg_display.sv
// -----------------------------------------------------------------------------
// count_seg_display
//
// Display stage for a 4-bit counter value (0..15). The value is sampled once
// per refresh frame, split into a tens digit (0/1) and a units digit (0..9),
// and time-multiplexed onto a 2-digit common-anode 7-segment display.
//
// A frame is two digit slots of REFRESH_DIV clocks each: the units slot first,
// then the tens slot. The first clock of every slot is dark so the previous
// digit's segments never bleed onto the newly enabled anode. The tens digit
// can be blanked when it is zero, and the whole display can blink with a
// half-period of BLINK_FRAMES frames.
//
// Parameters:
//   REFRESH_DIV   clk cycles per digit slot (>= 2)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous reset, active-low
//   count     in   [3:0] unsigned value to display, 0..15
//   blank_lz  in   1 = blank the tens digit when it is 0
//   blink_en  in   1 = blink the whole display
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   an        out  [1:0] digit anodes, active-low; an[0]=units, an[1]=tens
// -----------------------------------------------------------------------------
module count_seg_display #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [1:0] an
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int unsigned SCAN_W  = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  // Which digit slot of the frame is being scanned.
  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_e;

  // ---------------------------------------------------------------------------
  // 7-segment font, gfedcba, active-low
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] font(input logic [3:0] digit);
    logic [6:0] pattern;
    // NOTE: a default assigned before the case keeps this purely
    // combinational for every input value, so no latch is inferred.
    pattern = SEG_OFF;
    case (digit)
      4'd0: pattern = 7'h40;
      4'd1: pattern = 7'h79;
      4'd2: pattern = 7'h24;
      4'd3: pattern = 7'h30;
      4'd4: pattern = 7'h19;
      4'd5: pattern = 7'h12;
      4'd6: pattern = 7'h02;
      4'd7: pattern = 7'h78;
      4'd8: pattern = 7'h00;
      4'd9: pattern = 7'h10;
      default: pattern = SEG_OFF;
    endcase
    return pattern;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
  slot_e              dsel_q,      dsel_d;
  logic [3:0]         val_q,       val_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;
  logic [6:0]         seg_q,       seg_d;
  logic [1:0]         an_q,        an_d;

  logic scan_wrap;
  logic frame_end;
  logic tens;
  logic [3:0] units;
  logic dark;

  // ---------------------------------------------------------------------------
  // Next-state logic: scan counter, slot select, frame sample, blink timer
  // ---------------------------------------------------------------------------
  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    dsel_d      = dsel_q;
    val_d       = val_q;
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;

    scan_wrap = (scan_cnt_q == SCAN_LAST);
    // A frame ends when the tens slot (the second slot) finishes.
    frame_end = scan_wrap && (dsel_q == SLOT_TENS);

    if (scan_wrap) begin
      scan_cnt_d = '0;
      dsel_d     = (dsel_q == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
    end else begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    end

    // The value only changes between frames, so both digits of one frame
    // always come from the same sample.
    if (frame_end) begin
      val_d = count;
    end

    // Blink timer runs only while enabled; disabling it forces the lit phase
    // so the next enable always starts with a full lit half-period.
    if (!blink_en) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the current-cycle state (registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;

    tens  = (val_q >= 4'd10);
    units = tens ? (val_q - 4'd10) : val_q;

    // blink_en gates blink_off_q directly so that dropping blink_en lights
    // the display on the very next edge, not one cycle after the clear.
    dark = blink_en && blink_off_q;

    if ((scan_cnt_q == '0) || dark) begin
      // Dead-time cycle at the start of each slot, or blink-off phase.
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end else if (dsel_q == SLOT_UNITS) begin
      seg_d = font(units);
      an_d  = AN_UNITS;
    end else if (!(blank_lz && !tens)) begin
      seg_d = font({3'b000, tens});
      an_d  = AN_TENS;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      dsel_q      <= SLOT_UNITS;
      val_q       <= 4'd0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      dsel_q      <= dsel_d;
      val_q       <= val_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_count_seg_display.sv
// -----------------------------------------------------------------------------
// tb_count_seg_display
//
// Self-checking bench for count_seg_display with REFRESH_DIV=4, BLINK_FRAMES=2.
// Every cycle the outputs are compared with a behavioural model that derives
// the expected display from cycle position, the sampled value and the number
// of blink frames seen, using plain arithmetic. Directed sequences add fixed
// expected segment/anode constants for the key scenarios.
// -----------------------------------------------------------------------------
module tb_count_seg_display;

  localparam int R  = 4;
  localparam int BF = 2;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       blank_lz;
  logic       blink_en;
  logic [6:0] seg;
  logic [1:0] an;

  count_seg_display #(
    .REFRESH_DIV (R),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .seg     (seg),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_pos;   // cycles since reset release
  int m_val;   // value shown in the current frame
  int m_bf;    // frame ends seen while blink enabled

  logic [6:0] font_tbl [10];

  typedef struct {
    logic [3:0] cnt;
    logic       blz;
    logic [6:0] u_seg;
    logic [6:0] t_seg;
    logic [1:0] t_an;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_expect(output logic [6:0] es, output logic [1:0] ea);
    int  phase;
    int  slot;
    bit  dark;
    es = 7'h7F;
    ea = 2'b11;
    if (reset) begin
      phase = m_pos % R;
      slot  = (m_pos / R) % 2;
      dark  = blink_en && (((m_bf / BF) % 2) == 1);
      if (phase != 0 && !dark) begin
        if (slot == 0) begin
          ea = 2'b10;
          es = font_tbl[m_val % 10];
        end else if (!(blank_lz && m_val < 10)) begin
          ea = 2'b01;
          es = font_tbl[m_val / 10];
        end
      end
    end
  endtask

  task automatic model_update();
    if (!reset) begin
      m_pos = 0;
      m_val = 0;
      m_bf  = 0;
    end else begin
      if ((m_pos % (2 * R)) == (2 * R - 1)) begin
        m_val = int'(count);
        if (blink_en) m_bf++;
      end
      if (!blink_en) m_bf = 0;
      m_pos++;
    end
  endtask

  // One clock: predict, advance model, clock DUT, compare after the edge.
  task automatic tick();
    logic [6:0] es;
    logic [1:0] ea;
    model_expect(es, ea);
    model_update();
    @(posedge clk);
    #1;
    check("model_seg", seg, es);
    check("model_an", an, ea);
    check("an_not_both_low", (an == 2'b00), 1'b0);
  endtask

  // Run until the next frame starts, passing at least one frame end so that
  // the current count value is the one displayed.
  task automatic align();
    do tick(); while ((m_pos % (2 * R)) != 0);
  endtask

  // Check one full frame against constants; optionally change count at cycle chg_at.
  task automatic check_frame(input string name, input logic [6:0] u_seg,
                             input logic [6:0] t_seg, input logic [1:0] t_an,
                             input int chg_at, input logic [3:0] chg_val);
    for (int i = 0; i < 2 * R; i++) begin
      if (i == chg_at) count = chg_val;
      tick();
      if ((i % R) == 0) begin
        check({name, "_dead_seg"}, seg, 7'h7F);
        check({name, "_dead_an"}, an, 2'b11);
      end else if (i < R) begin
        check({name, "_units_seg"}, seg, u_seg);
        check({name, "_units_an"}, an, 2'b10);
      end else begin
        check({name, "_tens_seg"}, seg, t_seg);
        check({name, "_tens_an"}, an, t_an);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    font_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    vecs[0] = '{cnt: 4'd13, blz: 1'b0, u_seg: 7'h30, t_seg: 7'h79, t_an: 2'b01};
    vecs[1] = '{cnt: 4'd5,  blz: 1'b1, u_seg: 7'h12, t_seg: 7'h7F, t_an: 2'b11};
    vecs[2] = '{cnt: 4'd10, blz: 1'b1, u_seg: 7'h40, t_seg: 7'h79, t_an: 2'b01};
    vecs[3] = '{cnt: 4'd7,  blz: 1'b0, u_seg: 7'h78, t_seg: 7'h40, t_an: 2'b01};
    vecs[4] = '{cnt: 4'd0,  blz: 1'b1, u_seg: 7'h40, t_seg: 7'h7F, t_an: 2'b11};
    vecs[5] = '{cnt: 4'd15, blz: 1'b0, u_seg: 7'h12, t_seg: 7'h79, t_an: 2'b01};
    vecs[6] = '{cnt: 4'd9,  blz: 1'b0, u_seg: 7'h10, t_seg: 7'h40, t_an: 2'b01};
    vecs[7] = '{cnt: 4'd2,  blz: 1'b1, u_seg: 7'h24, t_seg: 7'h7F, t_an: 2'b11};

    m_pos = 0;
    m_val = 0;
    m_bf  = 0;

    // Reset held 3 cycles with count=7
    reset    = 1'b0;
    count    = 4'd7;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_seg", seg, 7'h7F);
      check("reset_an", an, 2'b11);
    end
    reset = 1'b1;
    check_frame("first_frame", 7'h40, 7'h40, 2'b01, -1, 4'd0);
    check_frame("second_frame", 7'h78, 7'h40, 2'b01, -1, 4'd0);

    // Table-driven digit/blanking vectors
    for (int v = 0; v < 8; v++) begin
      count    = vecs[v].cnt;
      blank_lz = vecs[v].blz;
      align();
      check_frame($sformatf("vec%0d", v), vecs[v].u_seg, vecs[v].t_seg, vecs[v].t_an, -1, 4'd0);
    end

    // count changes 3->9 mid units slot: frame keeps 3, next frame shows 9
    blank_lz = 1'b0;
    count    = 4'd3;
    align();
    check_frame("no_tear", 7'h30, 7'h40, 2'b01, 2, 4'd9);
    check_frame("after_tear", 7'h10, 7'h40, 2'b01, -1, 4'd0);

    // Blink: 2 frames lit, 2 dark, 2 lit, then drop enable mid dark phase
    count = 4'd13;
    align();
    blink_en = 1'b1;
    check_frame("blink_lit1", 7'h30, 7'h79, 2'b01, -1, 4'd0);
    check_frame("blink_lit2", 7'h30, 7'h79, 2'b01, -1, 4'd0);
    for (int i = 0; i < 4 * R; i++) begin
      tick();
      check("blink_dark_an", an, 2'b11);
      check("blink_dark_seg", seg, 7'h7F);
    end
    check_frame("blink_lit3", 7'h30, 7'h79, 2'b01, -1, 4'd0);
    check_frame("blink_lit4", 7'h30, 7'h79, 2'b01, -1, 4'd0);
    tick();
    tick();
    check("blink_dark2_an", an, 2'b11);
    blink_en = 1'b0;
    tick();
    check("blink_drop_an", an, 2'b10);
    check("blink_drop_seg", seg, 7'h30);
    for (int i = 0; i < 2 * R - 3; i++) tick();

    // Reset during the tens slot with count=15
    count = 4'd15;
    align();
    for (int i = 0; i < R + 2; i++) tick();
    check("pre_reset_tens_an", an, 2'b01);
    reset = 1'b0;
    tick();
    check("mid_reset_seg", seg, 7'h7F);
    check("mid_reset_an", an, 2'b11);
    tick();
    reset = 1'b1;
    check_frame("post_reset", 7'h40, 7'h40, 2'b01, -1, 4'd0);

    // Randomized stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      count = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)   blank_lz = ~blank_lz;
      if ($urandom_range(0, 59) == 0)  blink_en = ~blink_en;
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
